lsl_iter_shifter: RTL and testbench
===================================

// Module: lsl_iter_shifter
// PURPOSE
//  Multi-cycle logical-shift-left unit for the Cortex-M0 execute stage.
//  Implements LSL (imm5) and LSL (register) with ARMv6-M C/Z/N semantics.
//  It is the left-direction counterpart of the ALU's combinational LSR path.
//  Shifts STEP_BITS positions per clock under a start/busy/done handshake.
//  The core stalls on o_busy and writes back o_rd and flags on o_done.
// PARAMETERS
//  STEP_BITS  4  bit positions shifted per SHIFT cycle; power of 2, 1..8
// PORTS
//  i_clk    in   1   clock; all state updates on rising edge
//  i_rst_n  in   1   reset, asynchronous, active-low
//  i_start  in   1   request; sampled only in IDLE or DONE
//  i_mode   in   1   0 = LSL imm (amount = i_imm5), 1 = LSL reg (amount = i_rs[7:0])
//  i_rm     in   32  operand to shift
//  i_rs     in   32  shift-amount register; bits [31:8] ignored
//  i_imm5   in   5   immediate shift amount
//  i_c      in   1   current APSR.C; passed through when amount == 0
//  o_busy   out  1   high in SHIFT state
//  o_done   out  1   one-cycle pulse; o_rd and flags valid in that cycle
//  o_rd     out  32  shifted result; held until the next accepted start
//  o_c      out  1   carry out
//  o_z      out  1   o_rd == 0
//  o_n      out  1   o_rd[31]
// BEHAVIOUR
//  Reset (async, i_rst_n = 0): state IDLE; o_rd, o_c, o_z, o_n, o_busy, o_done all 0.
//  FSM states IDLE, SHIFT, DONE.
//   IDLE/DONE & i_start:
//    latch i_rm, amount n (8 bits), i_c.
//    n == 0: result = i_rm, C = i_c; go to DONE.
//    n > 32: result = 0, C = 0; go to DONE.
//    1 <= n <= 32: remaining = n; go to SHIFT.
//   SHIFT, per cycle:
//    k = min(STEP_BITS, remaining).
//    C <= value[32-k]; value <= value << k; remaining <= remaining - k.
//    When remaining - k == 0, go to DONE.
//   DONE: o_done = 1 for exactly this cycle.
//    With i_start: restart as in IDLE. Without i_start: go to IDLE.
//  Final C for 1..32 is rm[32-n]; n == 32 gives result 0, C = rm[0].
//  o_rd, o_c, o_z, o_n update only on DONE entry; stable through IDLE.
//  o_z and o_n are derived from the registered result, never from the in-flight value.
//  Latency, measured from the i_start sampling edge to the o_done cycle:
//   1 cycle when n == 0 or n > 32.
//   ceil(n/STEP_BITS) + 1 cycles otherwise.
//  i_start during SHIFT is ignored: no queueing, and the latched operands stay unchanged.
//  i_rm, i_rs, i_imm5, i_mode and i_c are sampled only at accept; later changes have no effect.
//  Reset asserted mid-SHIFT aborts immediately and returns all outputs to reset values.
//  No V flag output; the core preserves APSR.V.
// TESTING (STEP_BITS = 4)
//  imm, imm5 = 1, rm = 0x8000_0001
//   -> o_rd = 0x0000_0002, C = 1, Z = 0, N = 0; o_done 2 cycles after start.
//  imm, imm5 = 0, rm = 0xF000_0000, i_c = 1
//   -> o_rd = 0xF000_0000, C = 1, N = 1; o_done 1 cycle after start.
//  reg, rs = 0xFFFF_FF20 (n = 32), rm = 0x0000_0001
//   -> o_rd = 0, C = 1, Z = 1; o_done 9 cycles after start.
//  reg, rs = 0x0000_0021 (n = 33), rm = 0xFFFF_FFFF
//   -> o_rd = 0, C = 0, Z = 1; latency 1.
//  reg, rs = 0x0000_0105 (n = 5), rm = 0x0800_0000, plus a second start pulsed mid-SHIFT
//   -> o_rd = 0, C = 1, Z = 1; exactly one o_done, at cycle 3.
//  Start n = 20, deassert i_rst_n in cycle 2
//   -> o_busy = 0, o_rd = 0, no o_done.
//   Release reset and issue imm5 = 3, rm = 0x1 -> o_rd = 0x8, latency 2.

Source files
------------

// File: rtl/lsl_iter_shifter.sv
// Iterative logical-shift-left unit for the execute stage.
// Handles LSL (imm5) and LSL (register) with C/Z/N results, advancing
// STEP_BITS bit positions per SHIFT cycle under a start/busy/done handshake.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for i_start; results held from the last operation
// SHIFT | shifting the latched operand, o_busy high
// DONE  | o_done pulse; results valid; i_start here restarts immediately
module lsl_iter_shifter #(
   parameter int unsigned STEP_BITS = 4
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_start,
   input  logic        i_mode,
   input  logic [31:0] i_rm,
   input  logic [31:0] i_rs,
   input  logic [4:0]  i_imm5,
   input  logic        i_c,
   output logic        o_busy,
   output logic        o_done,
   output logic [31:0] o_rd,
   output logic        o_c,
   output logic        o_z,
   output logic        o_n
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_e;

   localparam logic [5:0] STEP = 6'(STEP_BITS);

   state_e      state_q, state_d;
   logic [31:0] val_q, val_d;
   logic [5:0]  rem_q, rem_d;
   logic [31:0] rd_q, rd_d;
   logic        c_q, c_d;
   logic        z_q, z_d;
   logic        n_q, n_d;

   logic [7:0]  amount;
   logic [5:0]  k;
   logic [32:0] ext;

   // Next-state logic: accept/classify amount, step the shift, load results on DONE entry
   always_comb begin
      state_d = state_q;
      val_d   = val_q;
      rem_d   = rem_q;
      rd_d    = rd_q;
      c_d     = c_q;
      z_d     = z_q;
      n_d     = n_q;
      amount  = i_mode ? i_rs[7:0] : {3'b000, i_imm5};
      k       = (rem_q < STEP) ? rem_q : STEP;
      // Bit 32 of the widened shift is value[32-k], i.e. the last bit shifted out.
      ext     = {1'b0, val_q} << k;

      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (i_start) begin
               if (amount == 8'd0) begin
                  rd_d    = i_rm;
                  c_d     = i_c;
                  z_d     = (i_rm == 32'd0);
                  n_d     = i_rm[31];
                  state_d = S_DONE;
               end else if (amount > 8'd32) begin
                  rd_d    = 32'd0;
                  c_d     = 1'b0;
                  z_d     = 1'b1;
                  n_d     = 1'b0;
                  state_d = S_DONE;
               end else begin
                  val_d   = i_rm;
                  rem_d   = amount[5:0];
                  state_d = S_SHIFT;
               end
            end
         end
         S_SHIFT: begin
            val_d = ext[31:0];
            rem_d = rem_q - k;
            if (rem_q == k) begin
               rd_d    = ext[31:0];
               c_d     = ext[32];
               z_d     = (ext[31:0] == 32'd0);
               n_d     = ext[31];
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any in-flight shift
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         val_q   <= 32'd0;
         rem_q   <= 6'd0;
         rd_q    <= 32'd0;
         c_q     <= 1'b0;
         z_q     <= 1'b0;
         n_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         val_q   <= val_d;
         rem_q   <= rem_d;
         rd_q    <= rd_d;
         c_q     <= c_d;
         z_q     <= z_d;
         n_q     <= n_d;
      end
   end

   assign o_busy = (state_q == S_SHIFT);
   assign o_done = (state_q == S_DONE);
   assign o_rd   = rd_q;
   assign o_c    = c_q;
   assign o_z    = z_q;
   assign o_n    = n_q;

endmodule

// File: tb/tb_lsl_iter_shifter.sv
// Directed + randomized bench for lsl_iter_shifter (STEP_BITS = 4).
module tb_lsl_iter_shifter;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        mode;
   logic [31:0] rm;
   logic [31:0] rs;
   logic [4:0]  imm5;
   logic        cin;
   logic        busy;
   logic        done;
   logic [31:0] rd;
   logic        c_o;
   logic        z_o;
   logic        n_o;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] rd;
      logic        c;
      logic        z;
      logic        n;
      int          lat;
   } exp_t;

   exp_t exp_q[$];

   lsl_iter_shifter #(.STEP_BITS(4)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_start (start),
      .i_mode  (mode),
      .i_rm    (rm),
      .i_rs    (rs),
      .i_imm5  (imm5),
      .i_c     (cin),
      .o_busy  (busy),
      .o_done  (done),
      .o_rd    (rd),
      .o_c     (c_o),
      .o_z     (z_o),
      .o_n     (n_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic exp_t model(input logic md, input logic [31:0] rsv, input logic [4:0] imm,
                                  input logic [31:0] rmv, input logic ci);
      logic [7:0]  amt;
      logic [63:0] w;
      exp_t        e;
      amt = md ? rsv[7:0] : {3'b000, imm};
      if (amt == 8'd0) begin
         e.rd  = rmv;
         e.c   = ci;
         e.lat = 1;
      end else if (amt > 8'd32) begin
         e.rd  = 32'd0;
         e.c   = 1'b0;
         e.lat = 1;
      end else begin
         w     = {32'd0, rmv} << amt;
         e.rd  = w[31:0];
         e.c   = w[32];
         e.lat = (int'(amt) + 3) / 4 + 1;
      end
      e.z = (e.rd == 32'd0);
      e.n = e.rd[31];
      return e;
   endfunction

   // Drive one request, push its expectation, wait for o_done and compare.
   // Returns at #1 after the edge entering DONE, so a following call restarts from DONE.
   task automatic run_op(input string tag, input logic md, input logic [31:0] rsv,
                         input logic [4:0] imm, input logic [31:0] rmv, input logic ci,
                         input bit pulse_mid);
      int   lat;
      bit   got;
      exp_t e;
      @(negedge clk);
      mode  = md;
      rs    = rsv;
      imm5  = imm;
      rm    = rmv;
      cin   = ci;
      start = 1'b1;
      exp_q.push_back(model(md, rsv, imm, rmv, ci));
      lat = 0;
      got = 0;
      while (!got && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
         if (lat == 1 && !pulse_mid) start = 1'b0;
         if (lat == 2) start = 1'b0;
         // Operands change after accept; they must have no effect.
         mode = $urandom_range(0, 1);
         rs   = $urandom;
         imm5 = 5'($urandom);
         rm   = $urandom;
         cin  = $urandom_range(0, 1);
         if (done) got = 1;
         else chk({tag, " busy_in_shift"}, {31'd0, busy}, 32'd1);
      end
      start = 1'b0;
      chk({tag, " done_seen"}, {31'd0, got}, 32'd1);
      e = exp_q.pop_front();
      if (got) begin
         chk({tag, " rd"},      rd,           e.rd);
         chk({tag, " c"},       {31'd0, c_o}, {31'd0, e.c});
         chk({tag, " z"},       {31'd0, z_o}, {31'd0, e.z});
         chk({tag, " n"},       {31'd0, n_o}, {31'd0, e.n});
         chk({tag, " latency"}, lat,          e.lat);
         chk({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
      end
   endtask

   initial begin
      int   dn;
      exp_t hold;
      logic [31:0] rsr;
      rst_n = 1'b0;
      start = 1'b0;
      mode  = 1'b0;
      rm    = 32'd0;
      rs    = 32'd0;
      imm5  = 5'd0;
      cin   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset busy", {31'd0, busy}, 32'd0);
      chk("reset done", {31'd0, done}, 32'd0);
      chk("reset rd",   rd,            32'd0);
      chk("reset czn",  {29'd0, c_o, z_o, n_o}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run_op("imm1",   1'b0, 32'd0,         5'd1, 32'h8000_0001, 1'b0, 0);
      run_op("imm0",   1'b0, 32'd0,         5'd0, 32'hF000_0000, 1'b1, 0);
      run_op("reg32",  1'b1, 32'hFFFF_FF20, 5'd0, 32'h0000_0001, 1'b0, 0);
      run_op("reg33",  1'b1, 32'h0000_0021, 5'd0, 32'hFFFF_FFFF, 1'b1, 0);
      run_op("reg31",  1'b1, 32'h0000_001F, 5'd0, 32'h0000_0003, 1'b0, 0);
      run_op("reg4",   1'b1, 32'h0000_0004, 5'd0, 32'h1234_5678, 1'b0, 0);
      run_op("regmid", 1'b1, 32'h0000_0105, 5'd0, 32'h0800_0000, 1'b0, 1);

      // Exactly one o_done for the mid-shift start; results held through IDLE.
      dn = 0;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (done) dn++;
      end
      chk("regmid extra_done", dn, 0);
      chk("regmid held_rd",    rd, 32'd0);
      chk("regmid held_c",     {31'd0, c_o}, 32'd1);
      chk("regmid idle_busy",  {31'd0, busy}, 32'd0);

      for (int i = 0; i < 12; i++) begin
         rsr = $urandom;
         if (i % 2 == 0) rsr[7:0] = 8'($urandom_range(0, 40));
         run_op("rand", 1'($urandom_range(0, 1)), rsr, 5'($urandom), $urandom,
                1'($urandom_range(0, 1)), 0);
      end

      run_op("imm0b", 1'b0, 32'd0, 5'd0, 32'hF000_0000, 1'b1, 0);
      hold = model(1'b0, 32'd0, 5'd0, 32'hF000_0000, 1'b1);
      @(negedge clk);
      chk("idle_hold rd", rd, hold.rd);

      // Reset asserted while shifting n = 20.
      @(negedge clk);
      mode  = 1'b0;
      imm5  = 5'd20;
      rm    = 32'hDEAD_BEEF;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("rstmid busy_before", {31'd0, busy}, 32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rstmid busy", {31'd0, busy}, 32'd0);
      chk("rstmid rd",   rd,            32'd0);
      chk("rstmid czn",  {29'd0, c_o, z_o, n_o}, 32'd0);
      dn = 0;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (done) dn++;
      end
      chk("rstmid no_done", dn, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op("after_rst", 1'b0, 32'd0, 5'd3, 32'h0000_0001, 1'b0, 0);

      chk("queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
